// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with manual load and prescaled auto-scan
module scan_decoder #(
  parameter int SEL_W = 4,
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic mode,
  input  logic load,
  input  logic [SEL_W-1:0] a,
  output logic [2**SEL_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic wrap
);
  localparam int N = 2**SEL_W;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  logic [PW-1:0] pcnt, pcnt_next;
  logic [SEL_W-1:0] idx_next;
  logic mode_q, step, restart;
  // A mode change or a load restarts the prescaler and suppresses the step that cycle
  always_comb begin
    restart = load || !mode || (mode != mode_q);
    step = en && !restart && (pcnt == PMAX);
    idx_next = !en ? idx : load ? a : step ? idx + 1'b1 : idx;
    pcnt_next = !en ? pcnt : (restart || pcnt == PMAX) ? '0 : pcnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      pcnt <= '0;
      y <= '0;
      wrap <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      idx <= idx_next;
      pcnt <= pcnt_next;
      y <= en ? N'(1) << idx_next : '0;
      wrap <= step && (idx == '1);
      if (en) mode_q <= mode;
    end
  end
endmodule
